proc_job_arbiter: RTL
=====================

Name: proc_job_arbiter

Overview:
Shares the processor's host-side data-memory port and its start/ready run control between two host requesters. Each requester wins a grant, then loads operands into data memory, launches a program run and reads results back. Holds the grant until the requester releases it. Sits between the host agents and the processor's dcen/dwen/dadr/dinp/dout/start/ready pins.

Parameters:
RD_LAT, 1, data-memory read latency in cycles from p_dcen to valid p_dout
TMO_CYC, 4096, run timeout in cycles (used only with JOB_TIMEOUT_EN)

Ports:
ck  in  1  clock
rb  in  1  reset, synchronous, active-high
req  in  2  per-requester bus request; bit i = requester i
gnt  out  2  one-hot grant
cen  in  2  per-requester memory access enable
wen  in  2  per-requester write enable (qualified by cen)
adr  in  18  requester i address at adr[9i+8:9i]
wdat  in  64  requester i write data at wdat[32i+31:32i]
run  in  2  per-requester run command (1-cycle pulse)
rdat  out  32  read data, shared by both requesters
rvld  out  2  read-data-valid pulse, bit i for requester i
done  out  2  run-complete pulse, bit i for requester i
err  out  2  run-timeout pulse, coincident with done (with JOB_TIMEOUT_EN only)
p_start  out  1  processor start
p_ready  in  1  processor ready
p_dcen  out  1  processor data-memory enable
p_dwen  out  1  processor data-memory write enable
p_dadr  out  9  processor data-memory address
p_dinp  out  32  processor data-memory write data
p_dout  in  32  processor data-memory read data

Behaviour:
- Reset (rb=1 at a ck edge): state IDLE. gnt, rvld, done, err, p_start, p_dcen and p_dwen are 0. Round-robin pointer = 0. Read pipeline is flushed.
- Reset mid-run aborts the run and drops the grant. The processor is not reset by this block.
- IDLE: if any req bit is set, grant the requester selected by round-robin. Priority goes to the requester after the one last granted; after reset, requester 0 has priority.
  - gnt is registered and asserts the cycle after the decision; state moves to GRANT.
  - If both requesters request, the one not served last wins.
- GRANT: the granted requester's cen/wen/adr/wdat are forwarded combinationally to p_dcen/p_dwen/p_dadr/p_dinp.
  - A non-granted requester's inputs are ignored and its request stays pending.
- Reads: a granted read (cen=1, wen=0) pulses rvld[i] exactly RD_LAT cycles later with rdat = p_dout.
  - rvld is tagged with the owner at issue, so it still pulses even if the grant has dropped.
- Release: the grant is released when req[i]=0 in GRANT and no read is in flight.
  - gnt goes to 0 the next cycle, state returns to IDLE, and the pointer advances.
  - When a read is in flight, release waits for its last rvld.
- run[i] in GRANT from the granted requester: state moves to RUN_PULSE.
  - If cen[i] is asserted in the same cycle, the memory access is performed and the run is also accepted.
  - run from a non-granted requester is ignored.
- RUN_PULSE: p_start=1 for exactly one cycle, then state moves to RUN_ARM.
  - p_dcen is forced to 0 from RUN_PULSE until the run completes, and granted cen is dropped.
- RUN_ARM: wait for p_ready=0, then move to RUN_WAIT.
- RUN_WAIT: on the first cycle with p_ready=1, pulse done[i] for one cycle and return to GRANT; the grant is kept.
- Dropping req during a run does not abort it; release is evaluated after return to GRANT.
- No combinational path from req to gnt. p_start and done are registered.

Optional Feature:
JOB_TIMEOUT_EN:
- Defined:
  - A counter is cleared on entry to RUN_PULSE and increments in RUN_ARM and RUN_WAIT.
  - If it reaches TMO_CYC before completion, done[i] and err[i] pulse together and state returns to GRANT.
  - A p_ready change arriving later is ignored.
- Undefined:
  - There is no counter, and err is tied to 0.
  - The block waits for the processor indefinitely.

Test Plan:
- Reset with req=2'b11 -> gnt=00 during reset; gnt=01 on the 2nd cycle after reset deasserts. Drop req[0] -> gnt=10 two cycles later.
- Requester 0 granted writes 0x0000_1234 to adr 5, then reads adr 5 -> p_dwen=1 with p_dadr=5 on the write cycle; rvld=01 and rdat=0x0000_1234 exactly RD_LAT cycles after the read.
- Requester 1 drives cen/wen writes while requester 0 is granted -> p_dcen follows requester 0 only; no write from requester 1 reaches memory.
- Run from requester 0, with the processor model dropping ready 1 cycle after start and raising it 20 cycles later -> one-cycle p_start; p_dcen=0 throughout; done=01 one cycle after ready rises; gnt stays 01.
- Repeated request from both requesters over 4 grant/release cycles -> grants alternate 01, 10, 01, 10.
- With JOB_TIMEOUT_EN and TMO_CYC=16, the processor never raises ready -> done=01 and err=01 pulse together 16 cycles after p_start; a later ready rise produces no done.

Source files
------------

// File: rtl/proc_job_arbiter.sv
// Two-requester arbiter for the processor host data-memory port and start/ready run control; optional run timeout via JOB_TIMEOUT_EN.
// Latency: gnt one cycle after the IDLE decision; rvld RD_LAT cycles after a read; done/err one cycle after completion or timeout.
// Backpressure: a non-granted requester stays pending on req; release is held off while a read is still in flight.
module proc_job_arbiter #(
    parameter int RD_LAT  = 1,
    parameter int TMO_CYC = 4096
) (
    input  logic        ck,
    input  logic        rb,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  cen,
    input  logic [1:0]  wen,
    input  logic [17:0] adr,
    input  logic [63:0] wdat,
    input  logic [1:0]  run,
    output logic [31:0] rdat,
    output logic [1:0]  rvld,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        p_start,
    input  logic        p_ready,
    output logic        p_dcen,
    output logic        p_dwen,
    output logic [8:0]  p_dadr,
    output logic [31:0] p_dinp,
    input  logic [31:0] p_dout
);

    typedef enum logic [2:0] {IDLE, GRANT, RUN_PULSE, RUN_ARM, RUN_WAIT} state_t;

    // Every read stage except the one presenting rvld counts as in flight.
    localparam logic [RD_LAT-1:0] STG_MASK = {RD_LAT{1'b1}} >> 1;

    state_t            st, st_nxt;
    logic              own;
    logic              ptr;
    logic              pick;
    logic              issue;
    logic              inflight;
    logic              fin;
    logic              tmo_hit;
    logic [RD_LAT-1:0] pv;
    logic [RD_LAT-1:0] po;

    assign p_dcen   = (st == GRANT) && cen[own];
    assign p_dwen   = p_dcen && wen[own];
    assign p_dadr   = own ? adr[17:9] : adr[8:0];
    assign p_dinp   = own ? wdat[63:32] : wdat[31:0];
    assign issue    = p_dcen && !wen[own];
    assign inflight = issue || (|(pv & STG_MASK));
    assign rdat     = p_dout;
    assign rvld     = pv[RD_LAT-1] ? (po[RD_LAT-1] ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        st_nxt = st;
        pick   = req[ptr] ? ptr : ~ptr;
        fin    = 1'b0;
        case (st)
            IDLE:      if (|req) st_nxt = GRANT;
            GRANT: begin
                if (run[own])
                    st_nxt = RUN_PULSE;
                else if (!req[own] && !inflight)
                    st_nxt = IDLE;
            end
            RUN_PULSE: st_nxt = RUN_ARM;
            RUN_ARM: begin
                if (tmo_hit) begin
                    st_nxt = GRANT;
                    fin    = 1'b1;
                end else if (!p_ready) begin
                    st_nxt = RUN_WAIT;
                end
            end
            RUN_WAIT: begin
                if (p_ready || tmo_hit) begin
                    st_nxt = GRANT;
                    fin    = 1'b1;
                end
            end
            default:   st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rb) begin
            st      <= IDLE;
            gnt     <= 2'b00;
            own     <= 1'b0;
            ptr     <= 1'b0;
            done    <= 2'b00;
            p_start <= 1'b0;
            pv      <= '0;
            po      <= '0;
        end else begin
            st      <= st_nxt;
            p_start <= (st_nxt == RUN_PULSE);
            done    <= fin ? (own ? 2'b10 : 2'b01) : 2'b00;
            if (st == IDLE && (|req)) begin
                own <= pick;
                gnt <= pick ? 2'b10 : 2'b01;
            end
            if (st == GRANT && st_nxt == IDLE) begin
                gnt <= 2'b00;
                ptr <= ~own;
            end
            // Owner tag travels with the read so rvld survives a grant drop.
            pv[0] <= issue;
            po[0] <= own;
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k] <= pv[k-1];
                po[k] <= po[k-1];
            end
        end
    end

`ifdef JOB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYC + 1);
    logic [CW-1:0] tmo_cnt;

    // Counts cycles from p_start, so the timeout is measured from the start pulse.
    always_ff @(posedge ck) begin
        if (rb)
            tmo_cnt <= '0;
        else if (st_nxt == RUN_PULSE)
            tmo_cnt <= '0;
        else if (st == RUN_PULSE || st == RUN_ARM || st == RUN_WAIT)
            tmo_cnt <= tmo_cnt + CW'(1);
    end

    assign tmo_hit = (st == RUN_ARM || st == RUN_WAIT) && (tmo_cnt == CW'(TMO_CYC - 1));

    always_ff @(posedge ck) begin
        if (rb)
            err <= 2'b00;
        else if (fin && tmo_hit && !(st == RUN_WAIT && p_ready))
            err <= own ? 2'b10 : 2'b01;
        else
            err <= 2'b00;
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 2'b00;
`endif

endmodule
